// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch stage for the 64-bit LEGv8 core.
// Holds the PC, requests one 32-bit word at a time over a req/ready
// handshake, presents the registered word until the consumer acknowledges
// it, then advances to PC+4 or to the resolved branch target. A misaligned
// next PC halts fetching with a sticky fault that only reset clears.
module ifetch_unit #(
    parameter int           N        = 64,
    parameter logic [N-1:0] PC_RESET = '0
) (
    input  logic         i_clk,
    input  logic         i_reset,
    output logic         o_imem_req,
    output logic [N-1:0] o_imem_addr,
    input  logic         i_imem_ready,
    input  logic [31:0]  i_imem_rdata,
    output logic         o_instr_valid,
    output logic [31:0]  o_instr,
    output logic [10:0]  o_op,
    output logic [N-1:0] o_instr_pc,
    input  logic         i_instr_ack,
    input  logic         i_pc_src,
    input  logic [N-1:0] i_branch_target,
    output logic         o_fault,
    output logic [31:0]  o_retired
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [N-1:0] PC_STEP = N'(4);

    state_t       r_state;
    state_t       w_next_state;
    logic [N-1:0] r_pc;
    logic [31:0]  r_instr;
    logic [N-1:0] r_instr_pc;
    logic [31:0]  r_retired;
    logic [N-1:0] w_next_pc;
    logic         w_misaligned;

    // Next-PC selection and FSM next-state; the PC sum wraps modulo 2^N.
    always_comb begin
        w_next_pc    = i_pc_src ? i_branch_target : (r_pc + PC_STEP);
        w_misaligned = (w_next_pc[1:0] != 2'b00);
        w_next_state = r_state;
        case (r_state)
            IDLE:    w_next_state = FETCH;
            FETCH:   if (i_imem_ready) w_next_state = HOLD;
            HOLD:    if (i_instr_ack) w_next_state = w_misaligned ? HALT : FETCH;
            HALT:    w_next_state = HALT;
            default: w_next_state = IDLE;
        endcase
    end

    // State register; reset always returns to the IDLE bubble.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Datapath: capture fetched word, count retirements, advance PC unless the target faults.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_pc       <= PC_RESET;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_retired  <= '0;
        end else begin
            if (r_state == FETCH && i_imem_ready) begin
                r_instr    <= i_imem_rdata;
                r_instr_pc <= r_pc;
            end
            if (r_state == HOLD && i_instr_ack) begin
                r_retired <= r_retired + 32'd1;
                if (!w_misaligned) begin
                    r_pc <= w_next_pc;
                end
            end
        end
    end

    assign o_imem_req    = (r_state == FETCH);
    assign o_imem_addr   = r_pc;
    assign o_instr_valid = (r_state == HOLD);
    assign o_instr       = r_instr;
    assign o_op          = r_instr[31:21];
    assign o_instr_pc    = r_instr_pc;
    assign o_fault       = (r_state == HALT);
    assign o_retired     = r_retired;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed testbench for ifetch_unit with PC_RESET = 0x100.
module tb_ifetch_unit;

    logic        clk;
    logic        reset;
    logic        imemReq;
    logic [63:0] imemAddr;
    logic        imemReady;
    logic [31:0] imemRdata;
    logic        instrValid;
    logic [31:0] instr;
    logic [10:0] op;
    logic [63:0] instrPc;
    logic        instrAck;
    logic        pcSrc;
    logic [63:0] branchTarget;
    logic        fault;
    logic [31:0] retired;

    int compared;
    int mismatched;

    ifetch_unit #(.N(64), .PC_RESET(64'h100)) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .o_imem_req      (imemReq),
        .o_imem_addr     (imemAddr),
        .i_imem_ready    (imemReady),
        .i_imem_rdata    (imemRdata),
        .o_instr_valid   (instrValid),
        .o_instr         (instr),
        .o_op            (op),
        .o_instr_pc      (instrPc),
        .i_instr_ack     (instrAck),
        .i_pc_src        (pcSrc),
        .i_branch_target (branchTarget),
        .o_fault         (fault),
        .o_retired       (retired)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        imemReady = 1'b0;
        imemRdata = 32'h0;
        instrAck = 1'b0;
        pcSrc = 1'b0;
        branchTarget = 64'h0;
        for (int i = 0; i < 3; i++) step();
        compared++; if (imemReq !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_req got=%h exp=0", imemReq); end
        compared++; if (imemAddr !== 64'h100) begin mismatched++; $display("[TB] FAIL reset_addr got=%h exp=100", imemAddr); end
        compared++; if (instrValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid got=%h exp=0", instrValid); end
        compared++; if (instr !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_instr got=%h exp=0", instr); end
        compared++; if (op !== 11'h0) begin mismatched++; $display("[TB] FAIL reset_op got=%h exp=0", op); end
        compared++; if (instrPc !== 64'h0) begin mismatched++; $display("[TB] FAIL reset_instr_pc got=%h exp=0", instrPc); end
        compared++; if (fault !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_fault got=%h exp=0", fault); end
        compared++; if (retired !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_retired got=%h exp=0", retired); end
        reset = 1'b1;
        step();
        compared++; if (imemReq !== 1'b1) begin mismatched++; $display("[TB] FAIL first_req got=%h exp=1", imemReq); end
        compared++; if (imemAddr !== 64'h100) begin mismatched++; $display("[TB] FAIL first_addr got=%h exp=100", imemAddr); end
    endtask

    task automatic test_sequential();
        logic [63:0] expAddr;
        imemReady = 1'b1;
        imemRdata = 32'hF84003E1;
        instrAck = 1'b1;
        pcSrc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            expAddr = 64'h100 + 64'(4 * i);
            compared++; if (instrValid !== 1'b1) begin mismatched++; $display("[TB] FAIL seq_valid[%0d] got=%h exp=1", i, instrValid); end
            compared++; if (op !== 11'b11111000010) begin mismatched++; $display("[TB] FAIL seq_op[%0d] got=%h exp=7c2", i, op); end
            compared++; if (instrPc !== expAddr) begin mismatched++; $display("[TB] FAIL seq_instr_pc[%0d] got=%h exp=%h", i, instrPc, expAddr); end
            compared++; if (imemReq !== 1'b0) begin mismatched++; $display("[TB] FAIL seq_hold_req[%0d] got=%h exp=0", i, imemReq); end
            step();
            expAddr = 64'h104 + 64'(4 * i);
            compared++; if (imemReq !== 1'b1) begin mismatched++; $display("[TB] FAIL seq_req[%0d] got=%h exp=1", i, imemReq); end
            compared++; if (imemAddr !== expAddr) begin mismatched++; $display("[TB] FAIL seq_addr[%0d] got=%h exp=%h", i, imemAddr, expAddr); end
            compared++; if (retired !== 32'(i + 1)) begin mismatched++; $display("[TB] FAIL seq_retired[%0d] got=%0d exp=%0d", i, retired, i + 1); end
        end
        imemReady = 1'b0;
        instrAck = 1'b0;
    endtask

    task automatic test_wait_states();
        for (int i = 0; i < 4; i++) begin
            step();
            compared++; if (imemReq !== 1'b1) begin mismatched++; $display("[TB] FAIL wait_req[%0d] got=%h exp=1", i, imemReq); end
            compared++; if (imemAddr !== 64'h10C) begin mismatched++; $display("[TB] FAIL wait_addr[%0d] got=%h exp=10c", i, imemAddr); end
            compared++; if (instrValid !== 1'b0) begin mismatched++; $display("[TB] FAIL wait_valid[%0d] got=%h exp=0", i, instrValid); end
        end
        imemRdata = 32'h8B020020;
        imemReady = 1'b1;
        step();
        imemReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            compared++; if (instrValid !== 1'b1) begin mismatched++; $display("[TB] FAIL held_valid[%0d] got=%h exp=1", i, instrValid); end
            compared++; if (instr !== 32'h8B020020) begin mismatched++; $display("[TB] FAIL held_instr[%0d] got=%h exp=8b020020", i, instr); end
            compared++; if (imemReq !== 1'b0) begin mismatched++; $display("[TB] FAIL held_req[%0d] got=%h exp=0", i, imemReq); end
            compared++; if (imemAddr !== 64'h10C) begin mismatched++; $display("[TB] FAIL held_addr[%0d] got=%h exp=10c", i, imemAddr); end
            if (i == 2) begin
                imemRdata = 32'hDEADBEEF;
                imemReady = 1'b1;
            end else begin
                imemReady = 1'b0;
            end
            step();
        end
        compared++; if (instr !== 32'h8B020020) begin mismatched++; $display("[TB] FAIL spurious_instr got=%h exp=8b020020", instr); end
        compared++; if (instrPc !== 64'h10C) begin mismatched++; $display("[TB] FAIL spurious_instr_pc got=%h exp=10c", instrPc); end
        imemReady = 1'b0;
        instrAck = 1'b1;
        step();
        instrAck = 1'b0;
        compared++; if (imemAddr !== 64'h110) begin mismatched++; $display("[TB] FAIL wait_next_addr got=%h exp=110", imemAddr); end
        compared++; if (retired !== 32'd4) begin mismatched++; $display("[TB] FAIL wait_retired got=%0d exp=4", retired); end
    endtask

    task automatic test_branch();
        imemRdata = 32'hB4000040;
        imemReady = 1'b1;
        step();
        imemReady = 1'b0;
        instrAck = 1'b1;
        pcSrc = 1'b1;
        branchTarget = 64'h40;
        step();
        compared++; if (imemAddr !== 64'h40) begin mismatched++; $display("[TB] FAIL branch_addr got=%h exp=40", imemAddr); end
        compared++; if (imemReq !== 1'b1) begin mismatched++; $display("[TB] FAIL branch_req got=%h exp=1", imemReq); end
        compared++; if (retired !== 32'd5) begin mismatched++; $display("[TB] FAIL branch_retired got=%0d exp=5", retired); end
        instrAck = 1'b0;
        imemReady = 1'b1;
        step();
        imemReady = 1'b0;
        instrAck = 1'b1;
        branchTarget = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        compared++; if (imemAddr !== 64'hFFFF_FFFF_FFFF_FFFC) begin mismatched++; $display("[TB] FAIL top_addr got=%h exp=fffffffffffffffc", imemAddr); end
        instrAck = 1'b0;
        imemReady = 1'b1;
        step();
        compared++; if (instrPc !== 64'hFFFF_FFFF_FFFF_FFFC) begin mismatched++; $display("[TB] FAIL top_instr_pc got=%h exp=fffffffffffffffc", instrPc); end
        imemReady = 1'b0;
        instrAck = 1'b1;
        pcSrc = 1'b0;
        branchTarget = 64'h123;
        step();
        instrAck = 1'b0;
        compared++; if (imemAddr !== 64'h0) begin mismatched++; $display("[TB] FAIL wrap_addr got=%h exp=0", imemAddr); end
        compared++; if (retired !== 32'd7) begin mismatched++; $display("[TB] FAIL wrap_retired got=%0d exp=7", retired); end
    endtask

    task automatic test_misaligned();
        imemRdata = 32'hB4000050;
        imemReady = 1'b1;
        step();
        imemReady = 1'b0;
        instrAck = 1'b1;
        pcSrc = 1'b1;
        branchTarget = 64'h42;
        step();
        for (int i = 0; i < 4; i++) begin
            compared++; if (fault !== 1'b1) begin mismatched++; $display("[TB] FAIL halt_fault[%0d] got=%h exp=1", i, fault); end
            compared++; if (imemReq !== 1'b0) begin mismatched++; $display("[TB] FAIL halt_req[%0d] got=%h exp=0", i, imemReq); end
            compared++; if (instrValid !== 1'b0) begin mismatched++; $display("[TB] FAIL halt_valid[%0d] got=%h exp=0", i, instrValid); end
            compared++; if (imemAddr !== 64'h0) begin mismatched++; $display("[TB] FAIL halt_addr[%0d] got=%h exp=0", i, imemAddr); end
            compared++; if (retired !== 32'd8) begin mismatched++; $display("[TB] FAIL halt_retired[%0d] got=%0d exp=8", i, retired); end
            imemReady = 1'b1;
            branchTarget = 64'h80;
            step();
        end
        imemReady = 1'b0;
        instrAck = 1'b0;
        pcSrc = 1'b0;
        reset = 1'b0;
        step();
        compared++; if (fault !== 1'b0) begin mismatched++; $display("[TB] FAIL halt_reset_fault got=%h exp=0", fault); end
        compared++; if (imemAddr !== 64'h100) begin mismatched++; $display("[TB] FAIL halt_reset_addr got=%h exp=100", imemAddr); end
        compared++; if (retired !== 32'd0) begin mismatched++; $display("[TB] FAIL halt_reset_retired got=%0d exp=0", retired); end
        reset = 1'b1;
        step();
        compared++; if (imemReq !== 1'b1) begin mismatched++; $display("[TB] FAIL restart_req got=%h exp=1", imemReq); end
        compared++; if (imemAddr !== 64'h100) begin mismatched++; $display("[TB] FAIL restart_addr got=%h exp=100", imemAddr); end
    endtask

    task automatic test_reset_mid_hold();
        imemRdata = 32'hF84003E1;
        imemReady = 1'b1;
        step();
        imemReady = 1'b0;
        compared++; if (instrValid !== 1'b1) begin mismatched++; $display("[TB] FAIL midhold_valid_before got=%h exp=1", instrValid); end
        instrAck = 1'b1;
        pcSrc = 1'b0;
        reset = 1'b0;
        step();
        compared++; if (retired !== 32'd0) begin mismatched++; $display("[TB] FAIL midhold_retired got=%0d exp=0", retired); end
        compared++; if (instrValid !== 1'b0) begin mismatched++; $display("[TB] FAIL midhold_valid got=%h exp=0", instrValid); end
        compared++; if (imemAddr !== 64'h100) begin mismatched++; $display("[TB] FAIL midhold_addr got=%h exp=100", imemAddr); end
        compared++; if (imemReq !== 1'b0) begin mismatched++; $display("[TB] FAIL midhold_req got=%h exp=0", imemReq); end
        compared++; if (instr !== 32'h0) begin mismatched++; $display("[TB] FAIL midhold_instr got=%h exp=0", instr); end
        instrAck = 1'b0;
        reset = 1'b1;
        step();
        compared++; if (imemReq !== 1'b1) begin mismatched++; $display("[TB] FAIL midhold_restart_req got=%h exp=1", imemReq); end
        compared++; if (imemAddr !== 64'h100) begin mismatched++; $display("[TB] FAIL midhold_restart_addr got=%h exp=100", imemAddr); end
    endtask

    // Run every scenario in order, then report the totals.
    initial begin
        compared = 0;
        mismatched = 0;
        test_reset();
        test_sequential();
        test_wait_states();
        test_branch();
        test_misaligned();
        test_reset_mid_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage for the 64-bit LEGv8 core. It holds the PC and requests 32-bit instruction words from instruction memory over a req/ready handshake. Each returned word is registered and presented to the main decoder (`op` = instr[31:21]) and the datapath until the consumer acknowledges it. On acknowledge, the PC advances to PC+4 or to the resolved branch target.

## Interface
Parameters:
- `N`, 64, PC/address width in bits
- `PC_RESET`, 0, PC value loaded on reset (word aligned)

Ports:
- `clk`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk` only
- `imem_req`  out  1  fetch request, held high until `imem_ready`
- `imem_addr`  out  N  fetch address, equals `pc`, stable while `imem_req`=1
- `imem_ready`  in  1  `imem_rdata` valid this cycle; meaningful only while `imem_req`=1
- `imem_rdata`  in  32  instruction word
- `instr_valid`  out  1  `instr`/`op`/`instr_pc` hold a valid instruction
- `instr`  out  32  registered instruction word
- `op`  out  11  `instr[31:21]`, to main decoder
- `instr_pc`  out  N  address the held instruction was fetched from
- `instr_ack`  in  1  consumer has executed the held instruction; meaningful only while `instr_valid`=1
- `pc_src`  in  1  with `instr_ack`: 1 selects `branch_target` (Branch & Zero), 0 selects PC+4
- `branch_target`  in  N  resolved branch address
- `fault`  out  1  sticky misaligned-target fault; fetching is halted
- `retired`  out  32  count of acknowledged instructions

## Operation
- Registers: `pc`[N], `instr`[32], `instr_pc`[N], `state`, `retired`[32].
- States:
  - IDLE: no request; unconditionally goes to FETCH next cycle.
  - FETCH: `imem_req`=1, `imem_addr`=`pc`. If `imem_ready`=1, capture `instr`←`imem_rdata` and `instr_pc`←`pc`, then go to HOLD. Otherwise remain in FETCH.
  - HOLD: `instr_valid`=1, `imem_req`=0. If `instr_ack`=1, compute the next PC and `retired`←`retired`+1.
    - If the next PC has bits [1:0]≠0, go to HALT and set `fault`. `pc` is not updated.
    - Otherwise `pc`←next PC and go to FETCH.
  - HALT: `imem_req`=0, `instr_valid`=0, `fault`=1. Left only by reset.
- Next PC: `pc_src` ? `branch_target` : `pc`+4. The sum is N bits and wraps modulo 2^N. `pc`+4 uses `pc`, not `instr_pc`; the two are equal in HOLD.
- `op` is always `instr[31:21]`, including when `instr_valid`=0. The decoder must qualify it with `instr_valid`.
- Ignored inputs:
  - `imem_ready` outside FETCH.
  - `instr_ack` outside HOLD.
  - `pc_src` and `branch_target` when `instr_ack`=0.
- `retired` wraps from 0xFFFF_FFFF to 0. It increments even on the acknowledge that faults, because that instruction did execute.

## Timing
- Reset (`reset`=0 at an edge) sets state=IDLE, `pc`=`PC_RESET`, `instr`=0, `instr_pc`=0, `retired`=0, `fault`=0. All outputs are therefore 0 on the cycle after the reset edge, and `imem_addr`=`PC_RESET`.
- A reset asserted mid-request or mid-HOLD aborts the request. A held instruction is dropped without being counted. `imem_req` falls on the cycle after the reset edge.
- First request is issued 1 cycle after reset is released (IDLE bubble).
- Fetch latency: if `imem_ready` rises in cycle t, `instr_valid`=1 from t+1. A zero-wait memory gives one instruction every 2 cycles (FETCH, HOLD).
- Acknowledge: `instr_ack` in cycle t gives `instr_valid`=0 and `imem_req`=1 with the new `imem_addr` at t+1. `retired` is updated at t+1.
- `imem_addr` changes only on a HOLD→FETCH transition or on reset, never while `imem_req`=1.
- Outputs are driven from registers and state only; there is no combinational path from `imem_ready` or `instr_ack` to outputs.

## Test plan
- Reset/startup: hold `reset`=0 for 3 cycles with `PC_RESET`=0x100. Expect all outputs 0 and `imem_addr`=0x100. After release, expect `imem_req`=1 exactly one cycle later with address 0x100.
- Sequential fetch: a zero-wait memory returns 0xF84003E1 (LDUR). Ack every HOLD cycle with `pc_src`=0.
  - Expect `op`=11'b11111000010 and `instr_pc`=0x100.
  - Expect subsequent addresses 0x104 and 0x108 on every 2nd cycle.
  - Expect `retired`=3 after three acks.
- Wait states and held ack: `imem_ready` is delayed 4 cycles, and `instr_ack` is held low 5 cycles in HOLD.
  - Expect `imem_addr` stable and `instr` unchanged throughout.
  - Expect a spurious `imem_ready` pulse during HOLD to be ignored.
- Branch and wrap:
  - Ack with `pc_src`=1 and `branch_target`=0x40: expect next `imem_addr`=0x40.
  - With `pc`=0xFFFF_FFFF_FFFF_FFFC, ack with `pc_src`=0: expect next address 0x0.
- Misaligned target: ack with `pc_src`=1 and `branch_target`=0x42. Expect `fault`=1 and `imem_req`=0 permanently, `retired` incremented, and `imem_addr` unchanged. A following reset clears `fault` and restarts at `PC_RESET`.
- Reset mid-HOLD: assert `reset`=0 while `instr_valid`=1 and `instr_ack`=1 in the same cycle. Expect `retired`=0, `instr_valid`=0 and `pc`=`PC_RESET` on the next cycle, with the ack ignored.
